// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   uart_state_e    : receiver FSM states
//   PARITY_*        : encodings of the PARITY_MODE parameter
//   parity_mismatch : parity check on a received word and its parity bit
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Words narrower than 9 bits are zero-extended by the caller, which does
    // not change the XOR. Even parity expects XOR(data, bit) = 0, odd expects 1.
    function automatic logic parity_mismatch(input logic [8:0] word,
                                             input logic       par_bit,
                                             input int         mode);
        logic x;
        x = ^{word, par_bit};
        return (mode == PARITY_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk, rst_n : clock and asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronised output; both flops reset to RESET_VAL
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state is always assigned with non-blocking (<=) so every
    // flop samples the pre-edge value of its source; blocking here would
    // collapse the two stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with a single-entry valid/ready output register.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en_rx        : receiver enable; low aborts any frame in progress
//   tick         : one-clk pulse at OVERSAMPLE x baud
//   u_rx         : asynchronous serial line, idle high
//   data         : received word (first bit on the line is bit 0)
//   rx_valid     : data holds an unread frame; cleared by rx_valid && rx_ready
//   rx_ready     : consumer accepts data
//   parity_err   : parity mismatch, sideband with data
//   frame_err    : a stop bit sampled low, sideband with data
//   overrun      : one-clk pulse when a completed frame is dropped
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = PARITY_EVEN,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_rx,
    input  logic                 tick,
    input  logic                 u_rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int               CNT_W     = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    // ------------------------------------------------------------------
    // Line synchronisation and start-edge detection
    // ------------------------------------------------------------------
    logic rx_s;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (u_rx),
        .q     (rx_s)
    );

    logic       rx_prev_q;
    logic [2:0] settle_q, settle_d;
    logic       line_fell;

    // The synchroniser leaves reset at 1, so a line already low at release
    // would look like a falling edge two clocks later. Edge detection is held
    // off until the synchroniser and rx_prev_q carry real line samples.
    assign settle_d  = {settle_q[1:0], 1'b1};
    assign line_fell = settle_q[2] & rx_prev_q & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q <= 1'b1;
            settle_q  <= '0;
        end else begin
            rx_prev_q <= rx_s;
            settle_q  <= settle_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    uart_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   frame_done;
    logic                   sample_full;

    assign sample_full = tick && (cnt_q == FULL_LAST);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;

        if (!en_rx) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
        end else begin
            // Tick counter runs in every active state; it restarts at each sample.
            if (state_q != ST_IDLE && tick) begin
                cnt_d = cnt_q + 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (line_fell) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end

                ST_START: begin
                    if (tick && cnt_q == HALF_LAST) begin
                        cnt_d   = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (sample_full) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == DATA_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (sample_full) begin
                        cnt_d   = '0;
                        perr_d  = parity_mismatch(9'(shift_q), rx_s, PARITY_MODE);
                        state_d = ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (sample_full) begin
                        cnt_d  = '0;
                        ferr_d = ferr_q | ~rx_s;
                        if (bit_q == STOP_LAST) begin
                            bit_d      = '0;
                            frame_done = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // ------------------------------------------------------------------
    // Output register and valid/ready handshake
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    always_comb begin
        data_d       = data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        // A frame completing in the handshake cycle replaces the accepted one;
        // otherwise an unread word is kept and the new frame is dropped.
        if (frame_done) begin
            if (!rx_valid_q || rx_ready) begin
                data_d       = shift_q;
                parity_err_d = perr_q;
                frame_err_d  = ferr_d;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            data_q       <= data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data       = data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: one default (even parity) instance and one
// odd-parity instance sharing the line. Tick every 4 clocks, 16 ticks per bit.
module tb_uart_rx_core;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_rx;
    logic       tick;
    logic       u_rx;
    logic       rx_ready;
    logic       rx_ready_odd;
    logic [7:0] data;
    logic       rx_valid, parity_err, frame_err, overrun;
    logic [7:0] data_odd;
    logic       rx_valid_odd, parity_err_odd, frame_err_odd, overrun_odd;

    int tests  = 0;
    int fails  = 0;
    int ovr_cnt = 0;
    int tick_div = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_div <= (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
        tick     <= (tick_div == TICK_DIV - 1);
    end

    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
    end

    uart_rx_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_rx      (en_rx),
        .tick       (tick),
        .u_rx       (u_rx),
        .data       (data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    uart_rx_core #(.PARITY_MODE(2)) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_rx      (en_rx),
        .tick       (tick),
        .u_rx       (u_rx),
        .data       (data_odd),
        .rx_valid   (rx_valid_odd),
        .rx_ready   (rx_ready_odd),
        .parity_err (parity_err_odd),
        .frame_err  (frame_err_odd),
        .overrun    (overrun_odd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        u_rx = 1'b0;
        clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            u_rx = d[i];
            clks(BIT_CLKS);
        end
        u_rx = par;
        clks(BIT_CLKS);
        u_rx = stop;
        clks(BIT_CLKS);
        u_rx = 1'b1;
        clks(BIT_CLKS);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!rx_valid && n < 4 * BIT_CLKS) begin
            clks(1);
            n++;
        end
        check(tag, rx_valid, 1'b1);
    endtask

    task automatic accept(input string tag);
        rx_ready = 1'b1;
        clks(1);
        rx_ready = 1'b0;
        check(tag, rx_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        en_rx        = 1'b1;
        u_rx         = 1'b1;
        rx_ready     = 1'b0;
        rx_ready_odd = 1'b1;
        clks(5);

        // Reset state
        check("rst_valid", rx_valid, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_perr", parity_err, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        rst_n = 1'b1;
        clks(2 * BIT_CLKS);
        check("idle_valid", rx_valid, 1'b0);

        // 0xA5, even parity bit 0, stop 1: clean frame
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_valid("a5_valid");
        check("a5_data", data, 8'hA5);
        check("a5_perr", parity_err, 1'b0);
        check("a5_ferr", frame_err, 1'b0);
        clks(20);
        check("a5_hold_valid", rx_valid, 1'b1);
        check("a5_hold_data", data, 8'hA5);
        accept("a5_accept");

        // 0x3C with parity bit 0: fine for even, error for odd instance
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_valid("3c_valid");
        check("3c_data", data, 8'h3C);
        check("3c_perr_even", parity_err, 1'b0);
        check("3c_odd_data", data_odd, 8'h3C);
        check("3c_odd_perr", parity_err_odd, 1'b1);
        check("3c_odd_ferr", frame_err_odd, 1'b0);
        accept("3c_accept");

        // 0x55 with stop bit low, then clean 0x0F
        send_frame(8'h55, 1'b0, 1'b0);
        wait_valid("55_valid");
        check("55_data", data, 8'h55);
        check("55_ferr", frame_err, 1'b1);
        check("55_perr", parity_err, 1'b0);
        accept("55_accept");
        clks(BIT_CLKS);
        send_frame(8'h0F, 1'b0, 1'b1);
        wait_valid("0f_valid");
        check("0f_data", data, 8'h0F);
        check("0f_ferr", frame_err, 1'b0);
        check("0f_perr", parity_err, 1'b0);
        accept("0f_accept");

        // Glitch: 5 ticks low on idle line, rejected at start-bit centre
        u_rx = 1'b0;
        clks(5 * TICK_DIV);
        u_rx = 1'b1;
        clks(3 * BIT_CLKS);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_data", data, 8'h0F);

        // Overrun: 0x11 unread, 0x22 dropped
        ovr_cnt = 0;
        send_frame(8'h11, 1'b0, 1'b1);
        wait_valid("11_valid");
        check("11_ovr_none", ovr_cnt, 0);
        send_frame(8'h22, 1'b0, 1'b1);
        check("ovr_pulses", ovr_cnt, 1);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_data", data, 8'h11);
        accept("11_accept");

        // Reset mid-DATA of 0x99 with the line left low across release
        ovr_cnt = 0;
        u_rx = 1'b0;
        clks(BIT_CLKS);
        u_rx = 1'b1;
        clks(BIT_CLKS);
        u_rx = 1'b0;
        clks(BIT_CLKS / 2);
        rst_n = 1'b0;
        clks(4);
        check("rst_mid_valid", rx_valid, 1'b0);
        rst_n = 1'b1;
        clks(3 * BIT_CLKS);
        check("break_valid", rx_valid, 1'b0);
        u_rx = 1'b1;
        clks(2 * BIT_CLKS);
        check("after_break_valid", rx_valid, 1'b0);
        send_frame(8'h42, 1'b0, 1'b1);
        wait_valid("42_valid");
        check("42_data", data, 8'h42);
        check("42_perr", parity_err, 1'b0);
        check("42_ferr", frame_err, 1'b0);
        check("42_ovr", ovr_cnt, 0);
        accept("42_accept");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit, even, legal 8..32.
REQ-003 SHALL have parameter PARITY_MODE, default 1, 0=none 1=even 2=odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port en_rx  input  1  receiver enable.
REQ-008 SHALL have port tick  input  1  one-clk pulse at OVERSAMPLE x baud.
REQ-009 SHALL have port u_rx  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port data  output  DATA_BITS  received word, LSB first on line.
REQ-011 SHALL have port rx_valid  output  1  data holds an unread frame.
REQ-012 SHALL have port rx_ready  input  1  consumer accepts data.
REQ-013 SHALL have port parity_err  output  1  sideband with data, parity mismatch.
REQ-014 SHALL have port frame_err  output  1  sideband with data, a stop bit sampled low.
REQ-015 SHALL have port overrun  output  1  one-clk pulse, frame dropped.

Function
REQ-016 SHALL pass u_rx through a 2-flop synchroniser (reset value 1); all sampling uses the synchronised value.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY_MODE=0.
REQ-018 IDLE: on falling edge of synchronised line with en_rx=1, go START, clear tick counter.
REQ-019 START: after OVERSAMPLE/2 ticks sample line; low -> DATA, high -> IDLE (glitch rejected, no output).
REQ-020 DATA/PARITY/STOP: sample every OVERSAMPLE ticks (bit centre); DATA shifts DATA_BITS samples LSB first.
REQ-021 Parity check: even => XOR(data,parity bit)=0, odd => =1; mismatch sets parity_err for that frame.
REQ-022 STOP: sample STOP_BITS bits; any low sets frame_err; after last stop sample return to IDLE same cycle.
REQ-023 Frame completion SHALL load data/parity_err/frame_err and assert rx_valid on the next clk; errored frames are still delivered.
REQ-024 rx_valid SHALL stay high and data stable until rx_valid && rx_ready, then deassert next clk.
REQ-025 Completion while rx_valid=1 and not accepted that same cycle: new frame discarded, old held, overrun pulsed one clk.
REQ-026 Completion in same cycle as handshake: new frame loaded, rx_valid stays high, no overrun.
REQ-027 en_rx deasserted mid-frame: abort to IDLE within one clk, partial frame discarded; held output unaffected.
REQ-028 Ticks absent: FSM holds state; no timeouts.
REQ-029 Line low in IDLE with no falling edge (stuck low / break after reset) SHALL NOT start a frame.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, counters 0, shift register 0, data 0, rx_valid 0, parity_err 0, frame_err 0, overrun 0, synchroniser 1.
REQ-031 Reset mid-frame discards the frame; first frame after release requires a fresh falling edge.
REQ-032 Reset deassertion is synchronised externally; block samples nothing on the release edge.

Structure
REQ-033 Shared package uart_pkg SHALL hold the state enum, PARITY_NONE/EVEN/ODD constants and a parity function.
REQ-034 Sub-module uart_sync2 (2-flop synchroniser, reset value parameter) SHALL be instantiated for u_rx.
REQ-035 Output register and handshake SHALL live in the top module; no FIFO.

Verification
REQ-036 Defaults, frame 0x A5 even parity=0, stop=1 -> rx_valid after stop sample, data=0xA5, no errors.
REQ-037 PARITY_MODE=2, frame 0x3C with parity bit 0 -> data=0x3C, parity_err=1, frame_err=0.
REQ-038 Stop bit driven low, frame 0x55 -> data=0x55, frame_err=1; next frame 0x0F received clean.
REQ-039 Low pulse of 5 ticks on idle line -> returns IDLE, rx_valid stays 0.
REQ-040 rx_ready=0, send 0x11 then 0x22 -> data=0x11 held, overrun one-clk pulse at 0x22 completion.
REQ-041 rst_n pulsed mid-DATA of 0x99, then send 0x42 -> only 0x42 delivered, all flags 0.
